// File: rtl/uart_tx_scheduler.sv
// UART TX scheduler: configures the UART baud divisor over AXI4 writes,
// then arbitrates two byte requesters round-robin into TX data writes.
module uart_tx_scheduler #(
    parameter logic [31:0] REGMAP        = 32'h1_0000,
    parameter int          DIVISOR       = 2604,
    parameter logic [31:0] TXDATA_OFFSET = 32'h4,
    parameter int          MAX_RETRY     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic [31:0] aw_addr,
    output logic        aw_valid,
    input  logic        aw_ready,
    output logic [31:0] w_data,
    output logic [3:0]  w_strb,
    output logic        w_last,
    output logic        w_valid,
    input  logic        w_ready,
    input  logic [1:0]  b_resp,
    input  logic        b_valid,
    output logic        b_ready,
    output logic        cfg_done,
    output logic        busy,
    output logic        err
);

    localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        CFG_REQ,
        CFG_RESP,
        IDLE,
        DATA_REQ,
        DATA_RESP
    } state_t;

    state_t        state_q, state_d;
    logic          aw_valid_q, aw_valid_d;
    logic          w_valid_q, w_valid_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic [31:0]   aw_addr_q, aw_addr_d;
    logic [31:0]   w_data_q, w_data_d;
    logic          b_ready_q, b_ready_d;
    logic          cfg_done_q, cfg_done_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          last_grant_q, last_grant_d;
    logic          hold_q, hold_d;

    logic          aw_fin, w_fin;
    logic          grant0, grant1;

    assign aw_addr  = aw_addr_q;
    assign aw_valid = aw_valid_q;
    assign w_data   = w_data_q;
    assign w_valid  = w_valid_q;
    assign w_strb   = 4'hF;
    assign w_last   = 1'b1;
    assign b_ready  = b_ready_q;
    assign cfg_done = cfg_done_q;
    assign busy     = busy_q;
    assign err      = err_q;

    // Next-state logic for the write sequencer and the round-robin arbiter.
    always_comb begin
        state_d      = state_q;
        aw_valid_d   = aw_valid_q;
        w_valid_d    = w_valid_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        aw_addr_d    = aw_addr_q;
        w_data_d     = w_data_q;
        b_ready_d    = b_ready_q;
        cfg_done_d   = cfg_done_q;
        err_d        = err_q;
        retry_d      = retry_q;
        last_grant_d = last_grant_q;
        hold_d       = hold_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;

        aw_fin = aw_done_q | (aw_valid_q & aw_ready);
        w_fin  = w_done_q | (w_valid_q & w_ready);
        grant0 = req0_valid & (~req1_valid | last_grant_q);
        grant1 = req1_valid & ~grant0;

        unique case (state_q)
            CFG_REQ, DATA_REQ: begin
                if (aw_valid_q & aw_ready) aw_valid_d = 1'b0;
                if (w_valid_q & w_ready) w_valid_d = 1'b0;
                aw_done_d = aw_fin;
                w_done_d  = w_fin;
                // Nothing issued yet: this is the first cycle after reset.
                if (state_q == CFG_REQ && !aw_valid_q && !w_valid_q &&
                    !aw_done_q && !w_done_q) begin
                    aw_valid_d = 1'b1;
                    w_valid_d  = 1'b1;
                    aw_addr_d  = REGMAP;
                    w_data_d   = 32'(DIVISOR);
                end else if (aw_fin && w_fin) begin
                    state_d   = (state_q == CFG_REQ) ? CFG_RESP : DATA_RESP;
                    b_ready_d = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            CFG_RESP: begin
                if (b_valid & b_ready_q) begin
                    b_ready_d = 1'b0;
                    if (b_resp == 2'b00) begin
                        cfg_done_d = 1'b1;
                        state_d    = IDLE;
                        hold_d     = 1'b1;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        if (retry_d < RW'(MAX_RETRY)) begin
                            state_d    = CFG_REQ;
                            aw_valid_d = 1'b1;
                            w_valid_d  = 1'b1;
                            aw_addr_d  = REGMAP;
                            w_data_d   = 32'(DIVISOR);
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                            hold_d  = 1'b1;
                        end
                    end
                end
            end
            IDLE: begin
                // One dead cycle after each return keeps the byte period at 4.
                if (hold_q) begin
                    hold_d = 1'b0;
                end else if (grant0 | grant1) begin
                    req0_ready   = grant0;
                    req1_ready   = grant1;
                    last_grant_d = grant1;
                    w_data_d     = {24'h0, grant0 ? req0_data : req1_data};
                    aw_addr_d    = REGMAP + TXDATA_OFFSET;
                    aw_valid_d   = 1'b1;
                    w_valid_d    = 1'b1;
                    state_d      = DATA_REQ;
                end
            end
            DATA_RESP: begin
                if (b_valid & b_ready_q) begin
                    b_ready_d = 1'b0;
                    if (b_resp != 2'b00) err_d = 1'b1;
                    state_d = IDLE;
                    hold_d  = 1'b1;
                end
            end
            default: state_d = CFG_REQ;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; async reset parks everything idle-low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CFG_REQ;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            b_ready_q    <= 1'b0;
            cfg_done_q   <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            retry_q      <= '0;
            last_grant_q <= 1'b1;
            hold_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            aw_valid_q   <= aw_valid_d;
            w_valid_q    <= w_valid_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            aw_addr_q    <= aw_addr_d;
            w_data_q     <= w_data_d;
            b_ready_q    <= b_ready_d;
            cfg_done_q   <= cfg_done_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            retry_q      <= retry_d;
            last_grant_q <= last_grant_d;
            hold_q       <= hold_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: config, arbitration table,
// back-pressure, error and mid-transaction reset sequences.
module tb_uart_tx_scheduler;

    localparam logic [31:0] REGMAP = 32'h1_0000;
    localparam logic [31:0] TXADDR = 32'h1_0004;
    localparam logic [31:0] DIVW   = 32'd2604;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0v, r1v, r0r, r1r;
    logic [7:0]  r0d, r1d;
    logic [31:0] aw_addr, w_data;
    logic        aw_valid, aw_ready, w_valid, w_ready;
    logic [3:0]  w_strb;
    logic        w_last;
    logic [1:0]  b_resp;
    logic        b_valid, b_ready;
    logic        cfg_done, busy, err;

    int checks = 0;
    int errors = 0;
    int awcnt = 0;
    int wcnt = 0;
    int cyc = 0;
    logic [31:0] last_aw = '0;
    logic [31:0] last_w = '0;

    typedef struct {
        logic       v0;
        logic       v1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       sel;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[9];

    uart_tx_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_data(r0d), .req0_ready(r0r),
        .req1_valid(r1v), .req1_data(r1d), .req1_ready(r1r),
        .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .w_valid(w_valid), .w_ready(w_ready),
        .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .cfg_done(cfg_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (rst_n && aw_valid && aw_ready) begin
            awcnt++;
            last_aw = aw_addr;
        end
        if (rst_n && w_valid && w_ready) begin
            wcnt++;
            last_w = w_data;
        end
    end

    always @(negedge clk) begin
        if (r0r || r1r) begin
            checks++;
            if (busy) begin
                errors++;
                $display("FAIL ready_outside_idle busy=%0b req0_ready=%0b req1_ready=%0b", busy, r0r, r1r);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic check_reset();
        chk("rst_aw_valid", {31'b0, aw_valid}, 0);
        chk("rst_w_valid", {31'b0, w_valid}, 0);
        chk("rst_b_ready", {31'b0, b_ready}, 0);
        chk("rst_aw_addr", aw_addr, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_readies", {30'b0, r1r, r0r}, 0);
        chk("rst_cfg_done", {31'b0, cfg_done}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 200; n++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk("idle_timeout", {31'b0, busy}, 0);
    endtask

    task automatic wait_grant(output logic sel, output bit ok);
        ok = 0;
        sel = 1'b0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (r0r || r1r) begin
                chk("one_hot_ready", {31'b0, r0r & r1r}, 0);
                sel = r1r;
                ok = 1;
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL grant_timeout got=none want=grant");
    endtask

    logic sel, exp_sel;
    bit ok;
    int t_last, a0, w0;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 8'h11};
        tbl[1] = '{1'b0, 1'b1, 8'h00, 8'h22, 1'b1, 8'h22};
        tbl[2] = '{1'b1, 1'b1, 8'h41, 8'h42, 1'b0, 8'h41};
        tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h42, 1'b1, 8'h42};
        tbl[4] = '{1'b1, 1'b1, 8'h33, 8'h44, 1'b0, 8'h33};
        tbl[5] = '{1'b1, 1'b1, 8'h55, 8'h66, 1'b1, 8'h66};
        tbl[6] = '{1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 8'hA5};
        tbl[7] = '{1'b1, 1'b1, 8'h00, 8'hFF, 1'b1, 8'hFF};
        tbl[8] = '{1'b1, 1'b1, 8'h01, 8'h02, 1'b0, 8'h01};

        rst_n = 1'b0;
        r0v = 0; r1v = 0; r0d = 0; r1d = 0;
        aw_ready = 1; w_ready = 1; b_valid = 1; b_resp = 2'b10;
        repeat (2) @(negedge clk);
        check_reset();

        // Config failing three times
        rst_n = 1'b1;
        @(negedge clk);
        chk("start_busy", {31'b0, busy}, 1);
        chk("start_aw_valid", {31'b0, aw_valid}, 1);
        chk("start_aw_addr", aw_addr, REGMAP);
        chk("start_w_data", w_data, DIVW);
        wait_idle();
        chk("retry_aw_count", awcnt, 3);
        chk("retry_w_count", wcnt, 3);
        chk("retry_err", {31'b0, err}, 1);
        chk("retry_cfg_done", {31'b0, cfg_done}, 0);

        // Clean config
        rst_n = 1'b0;
        b_resp = 2'b00;
        @(negedge clk);
        check_reset();
        awcnt = 0; wcnt = 0;
        rst_n = 1'b1;
        @(negedge clk);
        wait_idle();
        chk("cfg_aw_count", awcnt, 1);
        chk("cfg_w_count", wcnt, 1);
        chk("cfg_addr", last_aw, REGMAP);
        chk("cfg_data", last_w, DIVW);
        chk("cfg_done", {31'b0, cfg_done}, 1);
        chk("cfg_err", {31'b0, err}, 0);
        chk("strb_last", {27'b0, w_strb, w_last}, 32'h1F);

        // Arbitration table
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            r0v = tbl[i].v0; r1v = tbl[i].v1;
            r0d = tbl[i].d0; r1d = tbl[i].d1;
            wait_grant(sel, ok);
            if (ok) begin
                chk($sformatf("tbl%0d_sel", i), {31'b0, sel}, {31'b0, tbl[i].sel});
                @(negedge clk);
                r0v = 0; r1v = 0;
                chk($sformatf("tbl%0d_addr", i), aw_addr, TXADDR);
                chk($sformatf("tbl%0d_wdata", i), w_data, {24'h0, tbl[i].exp});
                wait_idle();
                chk($sformatf("tbl%0d_written", i), last_w, {24'h0, tbl[i].exp});
            end
        end

        // Both held: alternation and 4-cycle period
        @(negedge clk);
        r0v = 1; r1v = 1; r0d = 8'h10; r1d = 8'h20;
        exp_sel = 1'b1;
        t_last = 0;
        for (int k = 0; k < 6; k++) begin
            wait_grant(sel, ok);
            if (!ok) break;
            chk($sformatf("alt%0d_sel", k), {31'b0, sel}, {31'b0, exp_sel});
            if (k > 0) chk($sformatf("alt%0d_period", k), cyc - t_last, 4);
            t_last = cyc;
            @(negedge clk);
            if (k == 5) begin
                r0v = 0; r1v = 0;
            end
            chk($sformatf("alt%0d_wdata", k), w_data, exp_sel ? 32'h20 : 32'h10);
            exp_sel = ~exp_sel;
        end
        wait_idle();

        // W delayed three cycles behind AW
        w_ready = 0;
        @(negedge clk);
        r0v = 1; r0d = 8'h5A;
        wait_grant(sel, ok);
        @(negedge clk);
        r0v = 0;
        chk("bp_aw_valid_hi", {31'b0, aw_valid}, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_aw_low", k), {31'b0, aw_valid}, 0);
            chk($sformatf("bp%0d_w_hold", k), {31'b0, w_valid}, 1);
            chk($sformatf("bp%0d_w_data", k), w_data, 32'h5A);
            chk($sformatf("bp%0d_b_ready", k), {31'b0, b_ready}, 0);
        end
        w_ready = 1;
        @(negedge clk);
        chk("bp_w_dropped", {31'b0, w_valid}, 0);
        chk("bp_b_ready", {31'b0, b_ready}, 1);
        wait_idle();
        chk("bp_written", last_w, 32'h5A);

        // Data SLVERR sets err
        b_resp = 2'b10;
        @(negedge clk);
        r1v = 1; r1d = 8'h99;
        wait_grant(sel, ok);
        @(negedge clk);
        r1v = 0;
        wait_idle();
        chk("data_err", {31'b0, err}, 1);
        b_resp = 2'b00;

        // Reset during DATA_RESP
        b_valid = 0;
        @(negedge clk);
        r0v = 1; r0d = 8'h77;
        wait_grant(sel, ok);
        @(negedge clk);
        r0v = 0;
        for (int n = 0; n < 20; n++) begin
            if (b_ready) break;
            @(negedge clk);
        end
        chk("mid_b_ready", {31'b0, b_ready}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset();
        b_valid = 1;
        @(negedge clk);
        a0 = awcnt; w0 = wcnt;
        rst_n = 1'b1;
        @(negedge clk);
        chk("re_aw_valid", {31'b0, aw_valid}, 1);
        chk("re_aw_addr", aw_addr, REGMAP);
        wait_idle();
        chk("re_aw_count", awcnt - a0, 1);
        chk("re_w_count", wcnt - w0, 1);
        chk("re_data", last_w, DIVW);
        chk("re_cfg_done", {31'b0, cfg_done}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
